// File: rtl/nibble_serial_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : nibble_serial_alu_seq
//  Description : Drives one external 4-bit add/sub/mov/neg slice to run
//                W = 4*NIB bit MOV/NEG/ADD/SUB operations nibble-serially,
//                least-significant nibble first. Operands are latched on an
//                accepted START. The inter-nibble carry is registered. The
//                full result appears on y/co together with a one-cycle done.
//                Optional macro OVF_EN adds a signed-overflow output.
//  Revision    : 1.0  initial release
// ============================================================================
module nibble_serial_alu_seq #(
    parameter int NIB = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [4*NIB-1:0] a,
    input  logic [4*NIB-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [4*NIB-1:0] y,
    output logic             co,
`ifdef OVF_EN
    output logic             ovf,
`endif
    output logic             sl_ena,
    output logic             sl_sub,
    output logic [3:0]       sl_a,
    output logic [3:0]       sl_b,
    output logic             sl_ci,
    input  logic [3:0]       sl_y,
    input  logic             sl_co
);

    localparam int W  = 4 * NIB;
    localparam int CW = $clog2(NIB);

    localparam logic [CW-1:0] c_last = CW'(NIB - 1);
    localparam logic [1:0]    c_mov  = 2'b00;

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_run  = 2'd1;
    localparam logic [1:0] c_fin  = 2'd2;

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic [1:0]    r_op;
    logic [CW-1:0] r_cnt;
    logic          r_carry;
    logic [W-1:0]  r_res;
    logic          w_run;
    logic          w_accept;
    logic          w_last;

    // FIN behaves like IDLE, so a new request is taken in either state
    assign w_run    = (r_state == c_run);
    assign w_accept = start && !w_run;
    assign w_last   = w_run && (r_cnt == c_last);

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_idle:  w_state_nxt = start ? c_run : c_idle;
            c_run:   w_state_nxt = w_last ? c_fin : c_run;
            c_fin:   w_state_nxt = start ? c_run : c_idle;
            default: w_state_nxt = c_idle;
        endcase
    end

    // Status and slice-control outputs; the slice sees zeros whenever not running
    always_comb begin
        busy   = w_run;
        done   = (r_state == c_fin);
        sl_ena = w_run & r_op[1];
        sl_sub = w_run & r_op[0];
        sl_a   = w_run ? r_a[3:0] : 4'h0;
        sl_b   = w_run ? r_b[3:0] : 4'h0;
        sl_ci  = w_run & r_carry;
    end

`ifdef OVF_EN
    logic w_xa_ms;
    logic w_yb_ms;
    logic w_cin_ms;
    logic w_ovf;

    // Carry into the MS bit recovered from the slice's MS-bit sum, XORed with carry out
    assign w_xa_ms  = r_op[1] & r_a[3];
    assign w_yb_ms  = r_op[0] ^ r_b[3];
    assign w_cin_ms = sl_y[3] ^ w_xa_ms ^ w_yb_ms;
    assign w_ovf    = (r_op != c_mov) & (w_cin_ms ^ sl_co);

    // Overflow flag, updated together with y
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ovf <= 1'b0;
        end else if (w_last) begin
            ovf <= w_ovf;
        end
    end
`endif

    // Operand shift registers, carry chain, partial result and final result
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= 2'b00;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_res   <= '0;
            y       <= '0;
            co      <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_op    <= op;
            r_cnt   <= '0;
            // NEG/SUB use inverted B plus one, the +1 enters as initial carry
            r_carry <= op[0];
        end else if (w_run) begin
            r_a     <= {4'h0, r_a[W-1:4]};
            r_b     <= {4'h0, r_b[W-1:4]};
            r_res   <= {sl_y, r_res[W-1:4]};
            r_carry <= sl_co;
            r_cnt   <= r_cnt + 1'b1;
            if (w_last) begin
                y  <= {sl_y, r_res[W-1:4]};
                co <= sl_co;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nibble_serial_alu_seq
//  Description : Self-checking bench for nibble_serial_alu_seq with a
//                behavioural 4-bit slice, a whole-word reference model and
//                directed plus random stimulus.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_nibble_serial_alu_seq;

    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    logic         clk;
    logic         rstn;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] y;
    logic         co;
`ifdef OVF_EN
    logic         ovf;
`endif
    logic         sl_ena;
    logic         sl_sub;
    logic [3:0]   sl_a;
    logic [3:0]   sl_b;
    logic         sl_ci;
    logic [3:0]   sl_y;
    logic         sl_co;

    int n_chk  = 0;
    int n_pass = 0;
    logic cmp_en = 1'b0;
    logic [31:0] ci_hist;

    nibble_serial_alu_seq #(.NIB(NIB)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .y      (y),
        .co     (co),
`ifdef OVF_EN
        .ovf    (ovf),
`endif
        .sl_ena (sl_ena),
        .sl_sub (sl_sub),
        .sl_a   (sl_a),
        .sl_b   (sl_b),
        .sl_ci  (sl_ci),
        .sl_y   (sl_y),
        .sl_co  (sl_co)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External 4-bit slice: (ENA ? A : 0) + (SUB ? ~B : B) + CI
    always_comb begin
        logic [4:0] s;
        s = {1'b0, (sl_ena ? sl_a : 4'h0)} + {1'b0, (sl_sub ? ~sl_b : sl_b)} + {4'h0, sl_ci};
        sl_y  = s[3:0];
        sl_co = s[4];
    end

    // ---------------- reference model (whole-word arithmetic) ----------------
    function automatic logic [W:0] ref_res(input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv);
        logic [W:0] x, yv;
        x  = o[1] ? {1'b0, av} : '0;
        yv = o[0] ? {1'b0, ~bv} : {1'b0, bv};
        return x + yv + {{W{1'b0}}, o[0]};
    endfunction

    // Carry entering nibble k = carry out of the low 4k bits of the full sum
    function automatic logic ref_cin(input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv, input int k);
        logic [W+1:0] x, yv, s, msk;
        msk = ({{(W+1){1'b0}}, 1'b1} << (4 * k)) - 1'b1;
        x   = o[1] ? {2'b00, av} : '0;
        yv  = o[0] ? {2'b00, ~bv} : {2'b00, bv};
        s   = (x & msk) + (yv & msk) + {{(W+1){1'b0}}, o[0]};
        return s[4 * k];
    endfunction

    function automatic logic ref_ovf(input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv);
        logic [W:0] r;
        r = ref_res(o, av, bv);
        case (o)
            2'b10:   return (av[W-1] == bv[W-1]) && (r[W-1] != av[W-1]);
            2'b11:   return (av[W-1] != bv[W-1]) && (r[W-1] != av[W-1]);
            2'b01:   return bv == {1'b1, {(W-1){1'b0}}};
            default: return 1'b0;
        endcase
    endfunction

    logic         m_busy, m_done, m_co, m_ovf;
    logic [W-1:0] m_y, m_a, m_b;
    logic [1:0]   m_op;
    int           m_k;

    // Model: an accepted request finishes NIB clocks later, requests while busy vanish
    always @(posedge clk or negedge rstn) begin : model
        logic [W:0] r;
        if (!rstn) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_y <= '0; m_co <= 1'b0; m_ovf <= 1'b0;
            m_a <= '0; m_b <= '0; m_op <= 2'b00; m_k <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                if (m_k == NIB - 1) begin
                    r = ref_res(m_op, m_a, m_b);
                    m_y    <= r[W-1:0];
                    m_co   <= r[W];
                    m_ovf  <= ref_ovf(m_op, m_a, m_b);
                    m_done <= 1'b1;
                    m_busy <= 1'b0;
                end else begin
                    m_k <= m_k + 1;
                end
            end else if (start) begin
                m_busy <= 1'b1; m_k <= 0; m_op <= op; m_a <= a; m_b <= b;
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            logic [W-1:0] sa, sb;
            sa = m_a >> (4 * m_k);
            sb = m_b >> (4 * m_k);
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            chk("y", y, m_y);
            chk("co", co, m_co);
`ifdef OVF_EN
            chk("ovf", ovf, m_ovf);
`endif
            chk("sl_ena", sl_ena, m_busy & m_op[1]);
            chk("sl_sub", sl_sub, m_busy & m_op[0]);
            chk("sl_a", sl_a, m_busy ? sa[3:0] : 4'h0);
            chk("sl_b", sl_b, m_busy ? sb[3:0] : 4'h0);
            chk("sl_ci", sl_ci, m_busy ? ref_cin(m_op, m_a, m_b, m_k) : 1'b0);
        end
    end

    // ---------------- stimulus ----------------
    // Called on a falling edge; returns on the falling edge where done is seen
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv);
        int lat;
        start = 1'b1; op = o; a = av; b = bv;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        ci_hist = '0;
        while (done !== 1'b1 && lat < 20) begin
            ci_hist[lat-1] = sl_ci;
            @(negedge clk);
            lat++;
        end
        // E0 sits between the drive edge and lat=1, so done shows at lat=NIB+1
        chk("latency", lat, NIB + 1);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return {1'b1, {(W-1){1'b0}}};
            3:       return {1'b0, {(W-1){1'b1}}};
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        int nd;
        rstn = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
        @(negedge clk); @(negedge clk);
        cmp_en = 1'b1;
        chk("rst_y", y, 16'h0000);
        chk("rst_busy", busy, 1'b0);
        rstn = 1'b1;
        @(negedge clk);

        run_op(2'b10, 16'h1234, 16'h0FFF);
        chk("add_y", y, 16'h2233); chk("add_co", co, 1'b0);
        chk("add_ci_seq", ci_hist[3:0], 4'b1110);
        // Started on the done cycle of the previous op
        run_op(2'b11, 16'h0007, 16'h0005);
        chk("sub1_y", y, 16'h0002); chk("sub1_co", co, 1'b1);
        run_op(2'b11, 16'h0005, 16'h0007);
        chk("sub2_y", y, 16'hFFFE); chk("sub2_co", co, 1'b0);
        run_op(2'b01, 16'h0000, 16'h0001);
        chk("neg_y", y, 16'hFFFF); chk("neg_co", co, 1'b0);
        run_op(2'b00, 16'h5555, 16'hBEEF);
        chk("mov_y", y, 16'hBEEF); chk("mov_co", co, 1'b0);

        // Requests during busy are dropped
        @(negedge clk);
        start = 1'b1; op = 2'b10; a = 16'h1111; b = 16'h2222;
        @(negedge clk); start = 1'b1; op = 2'b11; a = 16'hFFFF; b = 16'h0001;
        @(negedge clk); start = 1'b0;
        @(negedge clk); start = 1'b1; op = 2'b00; a = 16'h0000; b = 16'h9999;
        @(negedge clk); start = 1'b0;
        nd = 0;
        for (int i = 0; i < 10; i++) begin
            if (done === 1'b1) nd++;
            @(negedge clk);
        end
        chk("busy_start_dones", nd, 1);
        chk("busy_start_y", y, 16'h3333);

        // Abort in the second RUN cycle
        start = 1'b1; op = 2'b10; a = 16'h1111; b = 16'h0001;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_y", y, 16'h0000);
        @(negedge clk); #2 rstn = 1'b1;
        nd = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done === 1'b1) nd++;
        end
        chk("abort_no_done", nd, 0);
        run_op(2'b10, 16'hFFFF, 16'h0001);
        chk("wrap_y", y, 16'h0000); chk("wrap_co", co, 1'b1);

`ifdef OVF_EN
        run_op(2'b10, 16'h7FFF, 16'h0001);
        chk("ovf_add_y", y, 16'h8000); chk("ovf_add", ovf, 1'b1);
        run_op(2'b01, 16'h0000, 16'h8000);
        chk("ovf_neg", ovf, 1'b1);
        run_op(2'b11, 16'h0000, 16'h0001);
        chk("ovf_sub", ovf, 1'b0);
`endif

        // Random traffic with one asynchronous abort in the middle
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) != 0);
            op    = 2'($urandom_range(0, 3));
            a     = pick();
            b     = pick();
            if (i == 300) begin
                #2 rstn = 1'b0;
                @(negedge clk);
                #2 rstn = 1'b1;
            end
        end
        @(negedge clk);
        start = 1'b0;
        repeat (NIB + 3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
